// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: latches header/target/range and launches one HM hash per nonce
// until a valid hash, range end, host abort or watchdog expiry.
module nonce_sweep_ctrl #(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header_in,
    input  logic [255:0] target_in,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    output logic         hm_begin_hash,
    output logic         hm_quit_hash,
    output logic [255:0] hm_difficulty,
    output logic [511:0] hm_data_to_hash,
    input  logic [1:0]   hm_hash_select,
    input  logic         hm_hash_done,
    input  logic         hm_valid_hash_flag,
    input  logic [255:0] hm_valid_hash,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  nonces_tried
);
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, QUIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [607:0]  hdr_q, hdr_d;
    logic [255:0]  tgt_q, tgt_d, fhash_q, fhash_d;
    logic [31:0]   n_q, n_d, last_q, last_d, fnonce_q, fnonce_d, tried_q, tried_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          found_q, found_d, exh_q, exh_d, to_q, to_d;
    logic [1023:0] pad;

    // SHA-256 padding of the 640-bit header: marker bit then the 64-bit length
    assign pad = {hdr_q, n_q, 1'b1, 319'd0, 64'd640};

    assign hm_data_to_hash = !n_rst ? '0 : (hm_hash_select == 2'd1 ? pad[511:0] : pad[1023:512]);
    assign busy            = state_q != IDLE;
    assign hm_begin_hash   = state_q == LAUNCH && !abort;
    assign hm_quit_hash    = state_q == QUIT;
    assign hm_difficulty   = busy ? tgt_q : '0;
    assign found           = found_q;
    assign exhausted       = exh_q;
    assign timeout         = to_q;
    assign found_nonce     = fnonce_q;
    assign found_hash      = fhash_q;
    assign nonces_tried    = tried_q;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        tgt_d    = tgt_q;
        n_d      = n_q;
        last_d   = last_q;
        fnonce_d = fnonce_q;
        fhash_d  = fhash_q;
        tried_d  = tried_q;
        found_d  = found_q;
        exh_d    = exh_q;
        to_d     = to_q;
        wd_d     = wd_q;
        unique case (state_q)
            IDLE: if (start) begin
                hdr_d    = header_in[639:32];
                tgt_d    = target_in;
                n_d      = nonce_first;
                last_d   = nonce_last;
                fnonce_d = '0;
                fhash_d  = '0;
                tried_d  = '0;
                found_d  = 1'b0;
                exh_d    = 1'b0;
                to_d     = 1'b0;
                state_d  = LAUNCH;
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = abort ? QUIT : WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (abort) begin
                    state_d = QUIT;
                end else if (hm_valid_hash_flag) begin
                    fnonce_d = n_q;
                    fhash_d  = hm_valid_hash;
                    found_d  = 1'b1;
                    tried_d  = tried_q + 32'd1;
                    state_d  = DONE;
                end else if (hm_hash_done && n_q == last_q) begin
                    exh_d   = 1'b1;
                    tried_d = tried_q + 32'd1;
                    state_d = DONE;
                end else if (hm_hash_done) begin
                    n_d     = n_q + 32'd1;
                    tried_d = tried_q + 32'd1;
                    state_d = LAUNCH;
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = QUIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            hdr_q    <= '0;
            tgt_q    <= '0;
            n_q      <= '0;
            last_q   <= '0;
            fnonce_q <= '0;
            fhash_q  <= '0;
            tried_q  <= '0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            to_q     <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            tgt_q    <= tgt_d;
            n_q      <= n_d;
            last_q   <= last_d;
            fnonce_q <= fnonce_d;
            fhash_q  <= fhash_d;
            tried_q  <= tried_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            to_q     <= to_d;
            wd_q     <= wd_d;
        end
    end
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb_nonce_sweep_ctrl: directed + randomized sweeps against a behavioural HM model;
// expected outcomes come from range arithmetic on the chosen nonces.
module tb_nonce_sweep_ctrl;
    logic         clk = 0, n_rst = 0, start = 0, abort = 0;
    logic [639:0] header_in = '0;
    logic [255:0] target_in = '0;
    logic [31:0]  nonce_first = '0, nonce_last = '0;
    logic [1:0]   hm_hash_select = 2'd1;
    logic         hm_hash_done = 0, hm_valid_hash_flag = 0;
    logic [255:0] hm_valid_hash = '0;

    logic         hm_begin_hash, hm_quit_hash, busy, found, exhausted, timeout;
    logic [255:0] hm_difficulty, found_hash;
    logic [511:0] hm_data_to_hash;
    logic [31:0]  found_nonce, nonces_tried;

    logic         begin_t, quit_t, busy_t, found_t, exh_t, to_t;
    logic [255:0] diff_t, fh_t;
    logic [511:0] data_t;
    logic [31:0]  fn_t, tried_t;

    int checks = 0, failures = 0;
    int mode = 0, lat = 5, cnt = 0, begins = 0, quits = 0;
    logic [31:0]  vn = '0, cur = '0;
    localparam logic [255:0] SALT = 256'h5a5a_1234_dead_beef_0bad_f00d_c0de_cafe_1111_2222_3333_4444_9876_5432_abcd_ef01;

    nonce_sweep_ctrl dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .header_in(header_in), .target_in(target_in),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .hm_begin_hash(hm_begin_hash), .hm_quit_hash(hm_quit_hash),
        .hm_difficulty(hm_difficulty), .hm_data_to_hash(hm_data_to_hash),
        .hm_hash_select(hm_hash_select), .hm_hash_done(hm_hash_done),
        .hm_valid_hash_flag(hm_valid_hash_flag), .hm_valid_hash(hm_valid_hash),
        .busy(busy), .found(found), .exhausted(exhausted), .timeout(timeout),
        .found_nonce(found_nonce), .found_hash(found_hash), .nonces_tried(nonces_tried)
    );

    nonce_sweep_ctrl #(.TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .header_in(header_in), .target_in(target_in),
        .nonce_first(nonce_first), .nonce_last(nonce_last),
        .hm_begin_hash(begin_t), .hm_quit_hash(quit_t),
        .hm_difficulty(diff_t), .hm_data_to_hash(data_t),
        .hm_hash_select(hm_hash_select), .hm_hash_done(hm_hash_done),
        .hm_valid_hash_flag(hm_valid_hash_flag), .hm_valid_hash(hm_valid_hash),
        .busy(busy_t), .found(found_t), .exhausted(exh_t), .timeout(to_t),
        .found_nonce(fn_t), .found_hash(fh_t), .nonces_tried(tried_t)
    );

    always #5 clk = ~clk;

    // HM model: mode 0 never valid, 1 valid alone, 2 valid with done, 3 never completes
    always @(negedge clk) begin
        hm_hash_done = 0;
        hm_valid_hash_flag = 0;
        if (!n_rst || hm_quit_hash) cnt = 0;
        else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                if ((mode == 1 || mode == 2) && cur == vn) begin
                    hm_valid_hash_flag = 1;
                    hm_valid_hash = {8{cur}} ^ SALT;
                    hm_hash_done = (mode == 2);
                end else hm_hash_done = (mode != 3);
            end
        end
        if (hm_begin_hash) begin
            begins++;
            cur = hm_data_to_hash[415:384];
            cnt = lat;
        end
        if (hm_quit_hash) quits++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle(input int bound);
        int i = 0;
        while (busy && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("idle_bound", busy, 0);
    endtask

    task automatic new_vals();
        for (int i = 0; i < 20; i++) header_in[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) target_in[i*32 +: 32] = $urandom;
    endtask

    task automatic sweep(input string tag, input logic [31:0] f, input logic [31:0] l,
                         input int m, input logic [31:0] v, input int lt, input bit poke);
        int b0;
        logic hit;
        logic [31:0] exp_tried;
        nonce_first = f;
        nonce_last = l;
        mode = m;
        vn = v;
        lat = lt;
        hit = (m == 1 || m == 2) && v >= f && v <= l;
        exp_tried = hit ? v - f + 1 : l - f + 1;
        b0 = begins;
        pulse_start();
        if (poke) begin
            repeat (3) @(negedge clk);
            nonce_first = f + 50;
            pulse_start();
        end
        wait_idle(int'(l - f + 2) * (lt + 4) + 20);
        chk({tag, "_found"}, found, hit);
        chk({tag, "_exhausted"}, exhausted, !hit);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_tried"}, nonces_tried, exp_tried);
        chk({tag, "_begins"}, begins - b0, exp_tried);
        if (hit) begin
            chk({tag, "_fnonce"}, found_nonce, v);
            chk({tag, "_fhash"}, found_hash, {8{v}} ^ SALT);
        end
    endtask

    initial begin
        int q0, len;
        logic [31:0] f;
        new_vals();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_begin", hm_begin_hash, 0);
        chk("rst_quit", hm_quit_hash, 0);
        chk("rst_diff", hm_difficulty, 0);
        chk("rst_data_hi", hm_data_to_hash[511:256], 0);
        chk("rst_data_lo", hm_data_to_hash[255:0], 0);
        chk("rst_flags", {found, exhausted, timeout}, 0);
        chk("rst_tried", nonces_tried, 0);
        n_rst = 1;
        @(negedge clk);

        header_in[639:608] = 32'h0100_0000;
        header_in[31:0] = 32'h0f2b_5710;
        sweep("t1", 0, 10, 1, 5, 80, 0);
        chk("t1_data_nonce", hm_data_to_hash[415:384], 5);
        chk("t1_data_marker", hm_data_to_hash[383], 1);
        chk("t1_data_len", hm_data_to_hash[63:0], 640);
        chk("t1_idle_diff", hm_difficulty, 0);
        hm_hash_select = 2'd0;
        #1;
        chk("sel0_hi", hm_data_to_hash[511:256], header_in[639:384]);
        chk("sel0_lo", hm_data_to_hash[255:0], header_in[383:128]);
        hm_hash_select = 2'd2;
        #1;
        chk("sel2_hi", hm_data_to_hash[511:256], header_in[639:384]);
        hm_hash_select = 2'd1;
        @(negedge clk);

        new_vals();
        sweep("wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, $urandom_range(2, 9), 0);
        chk("wrap_nonce", hm_data_to_hash[415:384], 32'hFFFF_FFFF);
        sweep("single", 32'h1234_5678, 32'h1234_5678, 0, 0, 3, 0);

        for (int r = 0; r < 5; r++) begin
            new_vals();
            f = $urandom_range(0, 32'hFFFF_0000);
            len = $urandom_range(0, 5);
            sweep("rnd", f, f + len, $urandom_range(0, 2), f + $urandom_range(0, len + 1),
                  $urandom_range(1, 12), 0);
        end

        new_vals();
        sweep("same", 0, 10, 2, 3, $urandom_range(4, 10), 1);

        new_vals();
        mode = 0;
        lat = 80;
        nonce_first = 20;
        nonce_last = 30;
        q0 = quits;
        pulse_start();
        chk("ab_begin", hm_begin_hash, 1);
        chk("ab_diff", hm_difficulty, target_in);
        repeat (10) @(negedge clk);
        abort = 1;
        @(negedge clk);
        chk("ab_quit", hm_quit_hash, 1);
        chk("ab_busy_q", busy, 1);
        abort = 0;
        @(negedge clk);
        chk("ab_quit_end", hm_quit_hash, 0);
        chk("ab_busy", busy, 0);
        chk("ab_flags", {found, exhausted, timeout}, 0);
        chk("ab_tried", nonces_tried, 0);
        chk("ab_quits", quits - q0, 1);

        mode = 3;
        lat = 5;
        nonce_first = 0;
        nonce_last = 3;
        pulse_start();
        chk("to_begin", begin_t, 1);
        repeat (16) @(negedge clk);
        chk("to_early", to_t, 0);
        @(negedge clk);
        chk("to_flag", to_t, 1);
        chk("to_quit", quit_t, 1);
        @(negedge clk);
        chk("to_quit_end", quit_t, 0);
        chk("to_busy", busy_t, 0);
        chk("to_hold", {found_t, exh_t, to_t}, 3'b001);
        abort = 1;
        @(negedge clk);
        abort = 0;
        wait_idle(10);

        mode = 0;
        lat = 20;
        nonce_first = 100;
        nonce_last = 200;
        pulse_start();
        repeat (50) @(negedge clk);
        n_rst = 0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_begin_quit", {hm_begin_hash, hm_quit_hash}, 0);
        chk("mr_diff", hm_difficulty, 0);
        chk("mr_data_hi", hm_data_to_hash[511:256], 0);
        chk("mr_data_lo", hm_data_to_hash[255:0], 0);
        chk("mr_tried", nonces_tried, 0);
        chk("mr_fnonce", found_nonce, 0);
        @(negedge clk);
        n_rst = 1;
        @(negedge clk);
        sweep("post_rst", 7, 9, 1, 8, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
